// File: rtl/frv_axi_pkg.sv
// Shared definitions for the AXI-lite SRAM slave: state encoding, bus widths
// and the SRAM window decode helper.
package frv_axi_pkg;

    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_STRB_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_COLLECT,
        ST_RD_ACC,
        ST_RD_WAIT,
        ST_RD_RESP,
        ST_WR_ACC,
        ST_WR_RESP
    } axi_state_t;

    // Unsigned offset compare: addresses below the base wrap to huge offsets.
    function automatic logic addr_in_window(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input int unsigned depth_log2);
        logic [32:0] offset;
        logic [32:0] limit;
        offset = {1'b0, addr - base};
        limit  = 33'd1 << (depth_log2 + 2);
        return offset < limit;
    endfunction

endpackage

// File: rtl/axi_sram_slave.sv
// AXI4-lite slave in front of a single-port synchronous SRAM (1-cycle read
// latency). One transaction in flight; reads and writes granted round-robin.
module axi_sram_slave
    import frv_axi_pkg::*;
#(
    parameter logic [31:0] MEM_BASE       = 32'h8000_0000,
    parameter int unsigned MEM_DEPTH_LOG2 = 12,
    parameter logic [31:0] RD_OOR_DATA    = 32'h0000_0000
) (
    input  logic                      g_clk,
    input  logic                      g_resetn,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [31:0]               s_axi_awaddr,
    input  logic [2:0]                s_axi_awprot,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    input  logic [AXI_DATA_W-1:0]     s_axi_wdata,
    input  logic [AXI_STRB_W-1:0]     s_axi_wstrb,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    input  logic [31:0]               s_axi_araddr,
    input  logic [2:0]                s_axi_arprot,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic [AXI_DATA_W-1:0]     s_axi_rdata,
    output logic                      ram_cen,
    output logic                      ram_wen,
    output logic [MEM_DEPTH_LOG2-1:0] ram_addr,
    output logic [AXI_DATA_W-1:0]     ram_wdata,
    output logic [AXI_STRB_W-1:0]     ram_wstrb,
    input  logic [AXI_DATA_W-1:0]     ram_rdata
);

    axi_state_t                state, state_nxt;
    logic                      last_was_read;
    logic                      aw_got, w_got, win_q;
    logic [MEM_DEPTH_LOG2-1:0] addr_q;
    logic [AXI_DATA_W-1:0]     wdata_q, rdata_q;
    logic [AXI_STRB_W-1:0]     wstrb_q;

    logic                      grant_rd, grant_wr;
    logic                      ar_hs, aw_hs, w_hs;
    logic [31:0]               req_addr, req_off;
    logic                      req_win;
    logic                      unused_bits;

    always_comb begin
        grant_rd      = 1'b0;
        grant_wr      = 1'b0;
        s_axi_arready = 1'b0;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_rvalid  = 1'b0;
        ram_cen       = 1'b0;
        ram_wen       = 1'b0;
        state_nxt     = state;

        if (state == ST_IDLE) begin
            grant_rd = s_axi_arvalid &
                       (~(s_axi_awvalid | s_axi_wvalid) | ~last_was_read);
            grant_wr = (s_axi_awvalid | s_axi_wvalid) &
                       (~s_axi_arvalid | last_was_read);
        end

        s_axi_arready = grant_rd;
        s_axi_awready = (grant_wr | (state == ST_WR_COLLECT)) & ~aw_got;
        s_axi_wready  = (grant_wr | (state == ST_WR_COLLECT)) & ~w_got;
        ar_hs = s_axi_arvalid & s_axi_arready;
        aw_hs = s_axi_awvalid & s_axi_awready;
        w_hs  = s_axi_wvalid  & s_axi_wready;

        unique case (state)
            ST_IDLE: begin
                if (ar_hs)               state_nxt = ST_RD_ACC;
                else if (aw_hs && w_hs)  state_nxt = ST_WR_ACC;
                else if (aw_hs || w_hs)  state_nxt = ST_WR_COLLECT;
            end
            ST_WR_COLLECT: begin
                if ((aw_got || aw_hs) && (w_got || w_hs)) state_nxt = ST_WR_ACC;
            end
            ST_WR_ACC: begin
                ram_cen   = win_q;
                ram_wen   = win_q;
                state_nxt = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) state_nxt = ST_IDLE;
            end
            ST_RD_ACC: begin
                ram_cen   = win_q;
                state_nxt = ST_RD_WAIT;
            end
            ST_RD_WAIT: state_nxt = ST_RD_RESP;
            ST_RD_RESP: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // AR and AW never handshake together, so one decode path serves both.
    assign req_addr = ar_hs ? s_axi_araddr : s_axi_awaddr;
    assign req_off  = req_addr - MEM_BASE;
    assign req_win  = addr_in_window(req_addr, MEM_BASE, MEM_DEPTH_LOG2);

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state         <= ST_IDLE;
            last_was_read <= 1'b0;
            aw_got        <= 1'b0;
            w_got         <= 1'b0;
            win_q         <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            rdata_q       <= '0;
        end else begin
            state <= state_nxt;
            if (grant_rd || grant_wr) last_was_read <= grant_rd;
            if (ar_hs || aw_hs) begin
                addr_q <= req_off[MEM_DEPTH_LOG2+1:2];
                win_q  <= req_win;
            end
            if (w_hs) begin
                wdata_q <= s_axi_wdata;
                wstrb_q <= s_axi_wstrb;
            end
            if (state_nxt == ST_IDLE) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else begin
                if (aw_hs) aw_got <= 1'b1;
                if (w_hs)  w_got  <= 1'b1;
            end
            if (state == ST_RD_WAIT) rdata_q <= win_q ? ram_rdata : RD_OOR_DATA;
        end
    end

    assign ram_addr    = addr_q;
    assign ram_wdata   = wdata_q;
    assign ram_wstrb   = wstrb_q;
    assign s_axi_rdata = rdata_q;

    assign unused_bits = ^{s_axi_awprot, s_axi_arprot, req_off[1:0],
                           req_off[31:MEM_DEPTH_LOG2+2]};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave with a behavioural
// single-port SRAM (one-cycle read latency) attached to the ram_* port.
module tb_axi_sram_slave;

    localparam logic [31:0] OOR = 32'hBAD0_0BAD;

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic        bready = 1'b0, rready = 1'b0;
    logic        awready, wready, arready, bvalid, rvalid;
    logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
    logic [3:0]  wstrb = '0;
    logic        ram_cen, ram_wen;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic [3:0]  ram_wstrb;

    logic [31:0] mem [0:4095];
    int          cen_count = 0;
    int          wr_count = 0;
    logic [11:0] last_waddr = '0;

    int check_count = 0;
    int pass_count = 0;

    always #5 g_clk = ~g_clk;

    axi_sram_slave #(
        .MEM_BASE       (32'h8000_0000),
        .MEM_DEPTH_LOG2 (12),
        .RD_OOR_DATA    (OOR)
    ) dut (
        .g_clk         (g_clk),
        .g_resetn      (g_resetn),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_awaddr  (awaddr),
        .s_axi_awprot  (3'b000),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_araddr  (araddr),
        .s_axi_arprot  (3'b000),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .s_axi_rdata   (rdata),
        .ram_cen       (ram_cen),
        .ram_wen       (ram_wen),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_wstrb     (ram_wstrb),
        .ram_rdata     (ram_rdata)
    );

    function automatic logic [31:0] merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    always @(posedge g_clk) begin
        if (ram_cen) begin
            cen_count <= cen_count + 1;
            if (ram_wen) begin
                wr_count       <= wr_count + 1;
                last_waddr     <= ram_addr;
                mem[ram_addr]  <= merge(mem[ram_addr], ram_wdata, ram_wstrb);
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge g_clk);
        @(negedge g_clk);
    endtask

    task automatic read_txn(input logic [31:0] addr, output logic [31:0] data,
                            output int lat);
        int n;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        #1;
        n = 0;
        while (arready !== 1'b1 && n < 20) begin tick(); n++; end
        tick();
        arvalid = 1'b0;
        lat = 1;
        while (rvalid !== 1'b1 && lat < 20) begin tick(); lat++; end
        data = rdata;
        tick();
    endtask

    task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output int lat);
        int n;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        #1;
        n = 0;
        while (!(awready === 1'b1 && wready === 1'b1) && n < 20) begin tick(); n++; end
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        lat = 1;
        while (bvalid !== 1'b1 && lat < 20) begin tick(); lat++; end
        tick();
    endtask

    task automatic test_reset();
        g_resetn = 1'b0;
        tick(); tick();
        check_count++;
        if ({arready, awready, wready, bvalid, rvalid, ram_cen, ram_wen} !== 7'b0)
            $display("FAIL reset_handshake: got %b exp 0000000",
                     {arready, awready, wready, bvalid, rvalid, ram_cen, ram_wen});
        else pass_count++;
        check_count++;
        if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h exp 00000000", rdata);
        else pass_count++;
        g_resetn = 1'b1;
        tick();
        check_count++;
        if ({arready, awready, wready, bvalid, rvalid, ram_cen} !== 6'b0)
            $display("FAIL idle_after_reset: got %b exp 000000",
                     {arready, awready, wready, bvalid, rvalid, ram_cen});
        else pass_count++;
    endtask

    task automatic test_write_aligned();
        awaddr = 32'h8000_0010; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        #1;
        check_count++;
        if ({awready, wready, arready} !== 3'b110)
            $display("FAIL wr_readies: got %b exp 110", {awready, wready, arready});
        else pass_count++;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        #1;
        check_count++;
        if ({ram_cen, ram_wen, ram_addr} !== {2'b11, 12'h004})
            $display("FAIL wr_acc_ctrl: got cen=%b wen=%b addr=%h exp 1 1 004",
                     ram_cen, ram_wen, ram_addr);
        else pass_count++;
        check_count++;
        if ({ram_wdata, ram_wstrb} !== {32'hDEAD_BEEF, 4'hF})
            $display("FAIL wr_acc_data: got %h/%h exp deadbeef/f", ram_wdata, ram_wstrb);
        else pass_count++;
        check_count++;
        if (bvalid !== 1'b0) $display("FAIL wr_bvalid_early: got %b exp 0", bvalid);
        else pass_count++;
        tick();
        check_count++;
        if ({bvalid, ram_cen} !== 2'b10)
            $display("FAIL wr_bvalid_at_2: got bvalid=%b cen=%b exp 1 0", bvalid, ram_cen);
        else pass_count++;
        tick();
        check_count++;
        if (bvalid !== 1'b0) $display("FAIL wr_bvalid_drop: got %b exp 0", bvalid);
        else pass_count++;
    endtask

    task automatic test_read();
        logic [31:0] d;
        int          lat;
        araddr = 32'h8000_0010; arvalid = 1'b1; rready = 1'b1;
        #1;
        check_count++;
        if ({arready, awready} !== 2'b10)
            $display("FAIL rd_readies: got %b exp 10", {arready, awready});
        else pass_count++;
        tick();
        arvalid = 1'b0;
        #1;
        check_count++;
        if ({ram_cen, ram_wen, ram_addr, rvalid} !== {2'b10, 12'h004, 1'b0})
            $display("FAIL rd_acc: got cen=%b wen=%b addr=%h rvalid=%b exp 1 0 004 0",
                     ram_cen, ram_wen, ram_addr, rvalid);
        else pass_count++;
        tick();
        check_count++;
        if ({rvalid, ram_cen} !== 2'b00)
            $display("FAIL rd_wait: got rvalid=%b cen=%b exp 0 0", rvalid, ram_cen);
        else pass_count++;
        tick();
        check_count++;
        if ({rvalid, rdata} !== {1'b1, 32'hDEAD_BEEF})
            $display("FAIL rd_resp: got rvalid=%b rdata=%h exp 1 deadbeef", rvalid, rdata);
        else pass_count++;
        tick();
        check_count++;
        if (rvalid !== 1'b0) $display("FAIL rd_rvalid_drop: got %b exp 0", rvalid);
        else pass_count++;
        read_txn(32'h8000_0013, d, lat);
        check_count++;
        if (d !== 32'hDEAD_BEEF) $display("FAIL rd_low_bits_ignored: got %h exp deadbeef", d);
        else pass_count++;
    endtask

    task automatic test_split_write();
        logic [31:0] d;
        int          lat;
        int          wc0;
        logic        bad;
        write_txn(32'h8000_0000, 32'hAABB_CCDD, 4'hF, lat);
        check_count++;
        if (lat !== 2) $display("FAIL wr_latency: got %0d exp 2", lat);
        else pass_count++;
        wc0 = wr_count;
        wdata = 32'h1234_5678; wstrb = 4'h3; wvalid = 1'b1; awvalid = 1'b0; bready = 1'b1;
        #1;
        check_count++;
        if (wready !== 1'b1) $display("FAIL split_wready: got %b exp 1", wready);
        else pass_count++;
        tick();
        wvalid = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bvalid !== 1'b0 || ram_cen !== 1'b0 || wready !== 1'b0 || awready !== 1'b1)
                bad = 1'b1;
            tick();
        end
        check_count++;
        if (bad !== 1'b0 || wr_count !== wc0)
            $display("FAIL split_wait: got bad=%b writes=%0d exp 0 %0d", bad, wr_count, wc0);
        else pass_count++;
        awaddr = 32'h8000_0000; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        #1;
        check_count++;
        if ({ram_cen, ram_wen, ram_addr, ram_wstrb, ram_wdata} !==
            {2'b11, 12'h000, 4'h3, 32'h1234_5678})
            $display("FAIL split_acc: got cen=%b wen=%b addr=%h strb=%h data=%h exp 1 1 000 3 12345678",
                     ram_cen, ram_wen, ram_addr, ram_wstrb, ram_wdata);
        else pass_count++;
        tick();
        check_count++;
        if (bvalid !== 1'b1) $display("FAIL split_bvalid: got %b exp 1", bvalid);
        else pass_count++;
        tick();
        check_count++;
        if (wr_count !== wc0 + 1) $display("FAIL split_single_write: got %0d exp %0d", wr_count, wc0 + 1);
        else pass_count++;
        read_txn(32'h8000_0000, d, lat);
        check_count++;
        if (d !== 32'hAABB_5678) $display("FAIL split_strobe_merge: got %h exp aabb5678", d);
        else pass_count++;
        check_count++;
        if (lat !== 3) $display("FAIL rd_latency: got %0d exp 3", lat);
        else pass_count++;
    endtask

    task automatic test_arbitration();
        logic [3:0]  kinds;
        int          when_c [4];
        int          exp_when [4];
        int          n;
        int          cyc;
        logic [31:0] d;
        int          lat;
        exp_when = '{0, 4, 7, 11};
        kinds = '0;
        g_resetn = 1'b0;
        tick();
        g_resetn = 1'b1;
        tick();
        araddr = 32'h8000_0010; awaddr = 32'h8000_0020;
        wdata = 32'h0BAD_F00D; wstrb = 4'hF;
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1; rready = 1'b1; bready = 1'b1;
        #1;
        n = 0;
        cyc = 0;
        while (n < 4 && cyc < 40) begin
            if (arready === 1'b1) begin
                kinds[n] = 1'b1; when_c[n] = cyc; n++;
            end else if (awready === 1'b1 && wready === 1'b1) begin
                kinds[n] = 1'b0; when_c[n] = cyc; n++;
            end
            tick();
            cyc++;
        end
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        tick(); tick(); tick();
        check_count++;
        if (n !== 4 || kinds !== 4'b0101)
            $display("FAIL arb_order: got n=%0d kinds=%b exp 4 0101", n, kinds);
        else pass_count++;
        for (int i = 0; i < 4; i++) begin
            check_count++;
            if (when_c[i] !== exp_when[i])
                $display("FAIL arb_cycle%0d: got %0d exp %0d", i, when_c[i], exp_when[i]);
            else pass_count++;
        end
        read_txn(32'h8000_0020, d, lat);
        check_count++;
        if (d !== 32'h0BAD_F00D) $display("FAIL arb_write_data: got %h exp 0badf00d", d);
        else pass_count++;
    endtask

    task automatic test_out_of_window();
        logic [31:0] d;
        int          lat;
        int          c0;
        c0 = cen_count;
        read_txn(32'h0000_1000, d, lat);
        check_count++;
        if (d !== OOR || lat !== 3)
            $display("FAIL oor_read: got %h lat %0d exp bad00bad lat 3", d, lat);
        else pass_count++;
        read_txn(32'h8000_4000, d, lat);
        check_count++;
        if (d !== OOR) $display("FAIL oor_read_past_end: got %h exp bad00bad", d);
        else pass_count++;
        write_txn(32'h7FFF_FFFC, 32'h1111_1111, 4'hF, lat);
        check_count++;
        if (lat !== 2) $display("FAIL oor_write_bvalid: got lat %0d exp 2", lat);
        else pass_count++;
        write_txn(32'h8000_4000, 32'h2222_2222, 4'hF, lat);
        check_count++;
        if (cen_count !== c0) $display("FAIL oor_no_cen: got %0d exp %0d", cen_count, c0);
        else pass_count++;
        write_txn(32'h8000_3FFC, 32'hCAFE_F00D, 4'hF, lat);
        check_count++;
        if (last_waddr !== 12'hFFF || cen_count !== c0 + 1)
            $display("FAIL top_word_write: got addr=%h cen=%0d exp fff %0d",
                     last_waddr, cen_count, c0 + 1);
        else pass_count++;
        read_txn(32'h8000_3FFC, d, lat);
        check_count++;
        if (d !== 32'hCAFE_F00D) $display("FAIL top_word_read: got %h exp cafef00d", d);
        else pass_count++;
    endtask

    task automatic test_reset_mid_read();
        logic bad;
        araddr = 32'h8000_0010; arvalid = 1'b1; rready = 1'b0;
        #1;
        tick();
        arvalid = 1'b0;
        tick(); tick();
        check_count++;
        if (rvalid !== 1'b1) $display("FAIL hold_rvalid: got %b exp 1", rvalid);
        else pass_count++;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rvalid !== 1'b1 || rdata !== 32'hDEAD_BEEF) bad = 1'b1;
        end
        check_count++;
        if (bad !== 1'b0) $display("FAIL hold_stable: got unstable=%b exp 0", bad);
        else pass_count++;
        #2;
        g_resetn = 1'b0;
        #1;
        check_count++;
        if (rvalid !== 1'b0) $display("FAIL async_reset_rvalid: got %b exp 0", rvalid);
        else pass_count++;
        check_count++;
        if (rdata !== 32'h0) $display("FAIL async_reset_rdata: got %h exp 00000000", rdata);
        else pass_count++;
        tick();
        g_resetn = 1'b1;
        rready = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rvalid !== 1'b0 || bvalid !== 1'b0 || ram_cen !== 1'b0 || arready !== 1'b0)
                bad = 1'b1;
        end
        check_count++;
        if (bad !== 1'b0) $display("FAIL stale_response: got activity=%b exp 0", bad);
        else pass_count++;
    endtask

    initial begin
        @(negedge g_clk);
        test_reset();
        test_write_aligned();
        test_read();
        test_split_write();
        test_arbitration();
        test_out_of_window();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
